// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: merges the two writeback lanes of the dual-issue pipe
// into an in-order queue that drains one register-file write per cycle.
// Lane 0 is older than lane 1 and is always enqueued first.
// Optional feature: define WB_PORT_FWD_EN to build the forwarding lookup.
// Without it, fwd_hit and fwd_data are tied to 0 and no comparators exist.
// Assumes AW <= 8, because the destination field is instr[8 +: AW].

// Per-lane entry formatter: extracts the destination register and selects
// the writeback data source.
module wb_lane_fmt #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          isld,
    input  logic [15:0]   instr,
    input  logic [DW-1:0] ldresult,
    input  logic [DW-1:0] aluresult,
    output logic [AW-1:0] rd,
    output logic [DW-1:0] data
);
    logic unused_instr;

    assign rd   = instr[8 +: AW];
    assign data = isld ? ldresult : aluresult;
    assign unused_instr = ^{instr[15:8+AW], instr[7:0]};
endmodule

module wb_port_scheduler #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 3,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1,
    localparam int NREG = 1 << AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iswb0,
    input  logic            isld0,
    input  logic [15:0]     instr0,
    input  logic [DW-1:0]   ldresult0,
    input  logic [DW-1:0]   aluresult0,
    input  logic            iswb1,
    input  logic            isld1,
    input  logic [15:0]     instr1,
    input  logic [DW-1:0]   ldresult1,
    input  logic [DW-1:0]   aluresult1,
    output logic            in_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] pending_mask,
    output logic [CW-1:0]   count,
    input  logic [AW-1:0]   fwd_raddr,
    output logic            fwd_hit,
    output logic [DW-1:0]   fwd_data
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]           lane_wb;
    logic [NUM_LANES-1:0]           lane_isld;
    logic [NUM_LANES-1:0][15:0]     lane_instr;
    logic [NUM_LANES-1:0][DW-1:0]   lane_ld;
    logic [NUM_LANES-1:0][DW-1:0]   lane_alu;
    logic [NUM_LANES-1:0][AW-1:0]   lane_rd;
    logic [NUM_LANES-1:0][DW-1:0]   lane_data;
    logic [NUM_LANES-1:0]           push;

    logic [DEPTH-1:0][AW-1:0] rd_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic                     pop;

    assign lane_wb    = {iswb1, iswb0};
    assign lane_isld  = {isld1, isld0};
    assign lane_instr = {instr1, instr0};
    assign lane_ld    = {ldresult1, ldresult0};
    assign lane_alu   = {aluresult1, aluresult0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        wb_lane_fmt #(.DW(DW), .AW(AW)) u_fmt (
            .isld      (lane_isld[g]),
            .instr     (lane_instr[g]),
            .ldresult  (lane_ld[g]),
            .aluresult (lane_alu[g]),
            .rd        (lane_rd[g]),
            .data      (lane_data[g])
        );
    end

    // Conservative: room for two is required even if only one lane pushes,
    // and the same-cycle pop is not credited.
    assign in_ready = (CW'(DEPTH) - count) >= CW'(2);
    assign push     = lane_wb & {NUM_LANES{in_ready}};
    assign pop      = (count != '0);

    assign rf_we    = pop;
    assign rf_waddr = pop ? rd_q[head]   : '0;
    assign rf_wdata = pop ? data_q[head] : '0;

    // Queue storage and pointers; lane 1 lands behind lane 0 only if lane 0
    // actually pushed, so there are never bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            if (push[0]) begin
                rd_q[tail]   <= lane_rd[0];
                data_q[tail] <= lane_data[0];
            end
            if (push[1]) begin
                rd_q[tail + PW'(push[0])]   <= lane_rd[1];
                data_q[tail + PW'(push[0])] <= lane_data[1];
            end
            head  <= head + PW'(pop);
            tail  <= tail + PW'(push[0]) + PW'(push[1]);
            count <= count + CW'(push[0]) + CW'(push[1]) - CW'(pop);
        end
    end

    // Scoreboard of destinations still in flight, head entry included.
    always_comb begin
        logic [PW-1:0] idx;
        pending_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count)
                pending_mask = pending_mask | (NREG'(1) << rd_q[idx]);
        end
    end

`ifdef WB_PORT_FWD_EN
    // Walk oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (rd_q[idx] == fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^fwd_raddr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule
